div16u8_seq: RTL and testbench

- Sequential 16-by-8 unsigned restoring divider. It is the inverse companion of the team's 8x8 unsigned multipliers: it takes a 16-bit product-range value and recovers the 8-bit quotient and 8-bit remainder.
- Used by the multiplier characterisation harness to check products (A*B / B == A, remainder 0).
- Also serves as a general-purpose divider in the arithmetic library.
- Computes one quotient bit per cycle, with valid/ready handshakes on both input and output.

---
 rtl/div16u8_seq_pkg.sv | 25 ++
 rtl/div16u8_seq_restore_step.sv | 26 ++
 rtl/div16u8_seq.sv | 156 +++++++++++++++
 tb/tb_div16u8_seq.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/div16u8_seq_pkg.sv
// div_pkg: shared definitions for the 16-by-8 sequential restoring divider.
//   W      : divisor / quotient / remainder width (dividend is 2*W bits)
//   CNT_W  : width of the iteration counter, sized to hold the value W
//   state_e: divider FSM states
//   ovf_check(): detects quotients that cannot fit in W bits
package div_pkg;

    localparam int W     = 8;
    localparam int CNT_W = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // The quotient overflows W bits exactly when the upper half of the
    // dividend is already >= the divisor. Divide-by-zero is reported
    // separately, so a zero divisor is never flagged as overflow here.
    function automatic logic ovf_check(input logic [W-1:0] hi,
                                       input logic [W-1:0] divisor);
        return (divisor != '0) && (hi >= divisor);
    endfunction

endpackage

// File: rtl/div16u8_seq_restore_step.sv
// div_restore_step: one combinational restoring-division step.
//   rem_i     : partial remainder R (W+1 bits)
//   bit_i     : next dividend bit shifted in from the low half
//   divisor_i : divisor
//   rem_o     : updated partial remainder
//   qbit_o    : quotient bit produced by this step
module div_restore_step
    import div_pkg::*;
(
    input  logic [W:0]   rem_i,
    input  logic         bit_i,
    input  logic [W-1:0] divisor_i,
    output logic [W:0]   rem_o,
    output logic         qbit_o
);

    logic [W:0] shifted;

    // R' = {R[W-1:0], bit}. The bit shifted out of R[W] acts as a carry: if
    // it is set, R' is certainly >= divisor, and the W+1 bit subtraction
    // below still yields the correct (small) remainder modulo 2^(W+1).
    assign shifted = {rem_i[W-1:0], bit_i};
    assign qbit_o  = rem_i[W] | (shifted >= {1'b0, divisor_i});
    assign rem_o   = qbit_o ? (shifted - {1'b0, divisor_i}) : shifted;

endmodule

// File: rtl/div16u8_seq.sv
// div16u8_seq: sequential 16-by-8 unsigned restoring divider, one quotient
// bit per cycle.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : operand handshake (dividend, divisor)
//   out_valid / out_ready: result handshake (quotient, remainder, flags)
//   div_zero             : divisor was zero (quotient all-ones,
//                          remainder = dividend low half)
//   overflow             : quotient does not fit in W bits (quotient and
//                          remainder all-ones)
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. Once out_valid is raised, the result outputs stay stable until
// out_ready is seen. in_ready is high only in IDLE, so there is never
// overlap between an output handshake and a new operand acceptance.
module div16u8_seq
    import div_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder,
    output logic           div_zero,
    output logic           overflow
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W:0]       rem_q, rem_d;
    // Low half of the dividend; quotient bits enter at the LSB as dividend
    // bits leave at the MSB, so after W steps it holds the quotient.
    logic [W-1:0]     lo_q, lo_d;
    logic [W-1:0]     div_q, div_d;
    logic [W-1:0]     quo_q, quo_d;
    logic [W-1:0]     rmd_q, rmd_d;
    logic             dz_q, dz_d;
    logic             ov_q, ov_d;
    // Error cases are classified at accept time and resolved in the first
    // CALC cycle, giving them a fixed one-cycle latency.
    logic             dz_pend_q, dz_pend_d;
    logic             ov_pend_q, ov_pend_d;

    logic [W:0]       step_rem;
    logic             step_qbit;

    div_restore_step u_step (
        .rem_i     (rem_q),
        .bit_i     (lo_q[W-1]),
        .divisor_i (div_q),
        .rem_o     (step_rem),
        .qbit_o    (step_qbit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            lo_q      <= '0;
            div_q     <= '0;
            quo_q     <= '0;
            rmd_q     <= '0;
            dz_q      <= 1'b0;
            ov_q      <= 1'b0;
            dz_pend_q <= 1'b0;
            ov_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            lo_q      <= lo_d;
            div_q     <= div_d;
            quo_q     <= quo_d;
            rmd_q     <= rmd_d;
            dz_q      <= dz_d;
            ov_q      <= ov_d;
            dz_pend_q <= dz_pend_d;
            ov_pend_q <= ov_pend_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        lo_d      = lo_q;
        div_d     = div_q;
        quo_d     = quo_q;
        rmd_d     = rmd_q;
        dz_d      = dz_q;
        ov_d      = ov_q;
        dz_pend_d = dz_pend_q;
        ov_pend_d = ov_pend_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d   = CALC;
                    div_d     = divisor;
                    rem_d     = {1'b0, dividend[2*W-1:W]};
                    lo_d      = dividend[W-1:0];
                    cnt_d     = CNT_W'(W);
                    dz_pend_d = (divisor == '0);
                    ov_pend_d = ovf_check(dividend[2*W-1:W], divisor);
                end
            end
            CALC: begin
                if (dz_pend_q) begin
                    state_d = DONE;
                    quo_d   = '1;
                    rmd_d   = lo_q;
                    dz_d    = 1'b1;
                    ov_d    = 1'b0;
                end else if (ov_pend_q) begin
                    state_d = DONE;
                    quo_d   = '1;
                    rmd_d   = '1;
                    dz_d    = 1'b0;
                    ov_d    = 1'b1;
                end else begin
                    rem_d = step_rem;
                    lo_d  = {lo_q[W-2:0], step_qbit};
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DONE;
                        quo_d   = {lo_q[W-2:0], step_qbit};
                        rmd_d   = step_rem[W-1:0];
                        dz_d    = 1'b0;
                        ov_d    = 1'b0;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign quotient  = quo_q;
    assign remainder = rmd_q;
    assign div_zero  = dz_q;
    assign overflow  = ov_q;

endmodule

// File: tb/tb_div16u8_seq.sv
module tb_div16u8_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        div_zero;
  logic        overflow;

  int pass_cnt;
  int total_cnt;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        dz;
    logic        ov;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  div16u8_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .overflow  (overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Drive one operand pair from IDLE, wait (bounded) for out_valid.
  // Returns when out_valid is seen; if out_ready is high the output
  // handshake edge is also consumed before returning.
  task automatic run_op(input logic [15:0] a, input logic [7:0] b,
                        output logic rdy, output logic [7:0] q, output logic [7:0] r,
                        output logic dz, output logic ov, output int lat);
    @(negedge clk);
    rdy = in_ready;
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    q  = quotient;
    r  = remainder;
    dz = div_zero;
    ov = overflow;
    if (out_ready && out_valid) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic       rdy, dz, ov;
  logic [7:0] q, r;
  int         lat;
  logic       seen;
  logic [7:0] b_list[9];
  logic [7:0] a_list[4];

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;

    //            a         b      q      r      dz    ov   lat
    vecs[0]  = '{16'h03E8, 8'h07, 8'h8E, 8'h06, 1'b0, 1'b0, 8};
    vecs[1]  = '{16'hFE01, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 8};
    vecs[2]  = '{16'h1234, 8'h00, 8'hFF, 8'h34, 1'b1, 1'b0, 1};
    vecs[3]  = '{16'h0100, 8'h01, 8'hFF, 8'hFF, 1'b0, 1'b1, 1};
    vecs[4]  = '{16'h00FF, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0, 8};
    vecs[5]  = '{16'h0064, 8'h0A, 8'h0A, 8'h00, 1'b0, 1'b0, 8};
    vecs[6]  = '{16'hFFFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b1, 1};
    vecs[7]  = '{16'h7FFF, 8'h80, 8'hFF, 8'h7F, 1'b0, 1'b0, 8};
    vecs[8]  = '{16'h0000, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0, 8};
    vecs[9]  = '{16'h1234, 8'h13, 8'hF5, 8'h05, 1'b0, 1'b0, 8};
    vecs[10] = '{16'h0000, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b0, 1};

    b_list = '{8'd1, 8'd2, 8'd3, 8'd7, 8'd16, 8'd85, 8'd128, 8'd254, 8'd255};
    a_list = '{8'd1, 8'h55, 8'hAA, 8'hFF};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset quotient", 32'(quotient), 32'd0);
    check("reset remainder", 32'(remainder), 32'd0);
    check("reset flags", 32'({div_zero, overflow}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed table
    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].a, vecs[i].b, rdy, q, r, dz, ov, lat);
      check($sformatf("vec%0d in_ready", i), 32'(rdy), 32'd1);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d quotient", i), 32'(q), 32'(vecs[i].q));
      check($sformatf("vec%0d remainder", i), 32'(r), 32'(vecs[i].r));
      check($sformatf("vec%0d div_zero", i), 32'(dz), 32'(vecs[i].dz));
      check($sformatf("vec%0d overflow", i), 32'(ov), 32'(vecs[i].ov));
      check($sformatf("vec%0d back to idle", i), 32'({in_ready, out_valid}), 32'b10);
    end

    // product sweep: (A*B)/B == A remainder 0
    for (int bi = 0; bi < 9; bi++) begin
      for (int a = 1; a < 256; a++) begin
        run_op(16'(a) * 16'(b_list[bi]), b_list[bi], rdy, q, r, dz, ov, lat);
        check($sformatf("sweep %0d*%0d", a, b_list[bi]),
              {14'd0, dz, ov, q, r}, {16'd0, 8'(a), 8'd0});
      end
    end
    for (int ai = 0; ai < 4; ai++) begin
      for (int b = 1; b < 256; b++) begin
        run_op(16'(a_list[ai]) * 16'(b), 8'(b), rdy, q, r, dz, ov, lat);
        check($sformatf("sweep %0d*%0d", a_list[ai], b),
              {14'd0, dz, ov, q, r}, {16'd0, a_list[ai], 8'd0});
      end
    end

    // backpressure: hold result for 5 cycles with in_valid pulses
    out_ready = 1'b0;
    run_op(16'h03E8, 8'h07, rdy, q, r, dz, ov, lat);
    check("bp latency", 32'(lat), 32'd8);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      dividend = 16'h0010;
      divisor  = 8'h02;
      @(posedge clk);
      #1;
      check($sformatf("bp%0d hold", c),
            {20'd0, out_valid, in_ready, div_zero, overflow, quotient, remainder},
            {20'd0, 4'b1000, 8'h8E, 8'h06});
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp release", 32'({in_ready, out_valid}), 32'b10);
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("bp no stray result", 32'(seen), 32'd0);

    // reset in the middle of CALC (after step 4)
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 16'h03E8;
    divisor  = 8'h07;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst ready/valid", 32'({in_ready, out_valid}), 32'b10);
    check("midrst outputs", {14'd0, div_zero, overflow, quotient, remainder}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("midrst aborted", 32'(seen), 32'd0);
    run_op(16'h0064, 8'h0A, rdy, q, r, dz, ov, lat);
    check("post-rst latency", 32'(lat), 32'd8);
    check("post-rst result", {14'd0, dz, ov, q, r}, {16'd0, 8'h0A, 8'h00});

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
